elevator_req_queue: RTL

//  Parametrised FIFO for elevator floor requests; next generation of the 8x4 request FIFO.

---
 rtl/elevator_pkg.sv | 22 ++
 rtl/elevator_req_match.sv | 23 ++
 rtl/elevator_req_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and width helpers for the elevator request path (queue and car controller).
package elevator_pkg;

    // Default floor-code width used across the elevator blocks.
    localparam int FLOOR_W_DEF = 4;

    typedef logic [FLOOR_W_DEF-1:0] floor_t;

    // Value presented on dout before any floor has been popped.
    localparam floor_t EMPTY_FLOOR = '0;

    // Width of a read/write pointer into a DEPTH-entry queue.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of an occupancy counter that must be able to hold DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/elevator_req_match.sv
// Duplicate-floor detector: compares an incoming floor code against every valid queue slot.
module elevator_req_match #(
    parameter int FLOOR_W = 4,
    parameter int DEPTH   = 8
) (
    input  logic [FLOOR_W-1:0]            din_i,
    input  logic [DEPTH-1:0][FLOOR_W-1:0] slots_i,
    input  logic [DEPTH-1:0]              valid_i,
    output logic                          dup_o
);

    logic [DEPTH-1:0] hit;

    // One comparator per slot; a slot only counts while its valid bit is set.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid_i[i] && (slots_i[i] == din_i);
        end
    end

    assign dup_o = |hit;

endmodule

// File: rtl/elevator_req_queue.sv
// Floor-request FIFO between the call-button encoder and the car controller.
// Registered status flags derived from the next count, optional duplicate
// suppression, emergency flush and a read-data valid strobe.
module elevator_req_queue
    import elevator_pkg::*;
#(
    parameter int FLOOR_W   = 4,
    parameter int DEPTH     = 8,
    parameter int DEDUP     = 1,
    parameter int AF_THRESH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [FLOOR_W-1:0]     din,
    input  logic                   rd_en,
    output logic [FLOOR_W-1:0]     dout,
    output logic                   dout_valid,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   wr_drop
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    // Storage and bookkeeping state.
    logic [DEPTH-1:0][FLOOR_W-1:0] mem_q;
    logic [DEPTH-1:0]              valid_q,      valid_d;
    logic [PTR_W-1:0]              wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]              count_q,      count_d;
    logic [FLOOR_W-1:0]            dout_q,       dout_d;
    logic                          dout_valid_q, dout_valid_d;
    logic                          wr_drop_q,    wr_drop_d;
    logic                          empty_q,      empty_d;
    logic                          full_q,       full_d;
    logic                          af_q,         af_d;

    logic dup;
    logic rd_acc;
    logic wr_acc;
    logic mem_we;

    // Duplicate detection is only built when suppression is enabled.
    generate
        if (DEDUP != 0) begin : g_dedup
            elevator_req_match #(
                .FLOOR_W (FLOOR_W),
                .DEPTH   (DEPTH)
            ) u_match (
                .din_i   (din),
                .slots_i (mem_q),
                .valid_i (valid_q),
                .dup_o   (dup)
            );
        end else begin : g_no_dedup
            assign dup = 1'b0;
        end
    endgenerate

    // A pop needs data; a push needs room (or a same-cycle pop) and a fresh floor.
    assign rd_acc = rd_en && !empty_q;
    assign wr_acc = wr_en && (!full_q || rd_acc) && !dup;
    assign mem_we = wr_acc && !flush;

    // Next-state computation for pointers, count, valid bits and output strobes.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        valid_d      = valid_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        wr_drop_d    = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = '0;
        end else begin
            if (rd_acc) begin
                dout_d            = mem_q[rd_ptr_q];
                dout_valid_d      = 1'b1;
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + PTR_W'(1);
            end
            // Applied after the pop so a full-queue push+pop re-validates the shared slot.
            if (wr_acc) begin
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            wr_drop_d = wr_en && !wr_acc;
            count_d   = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
        af_d    = (count_d >= CNT_W'(AF_THRESH));
    end

    // Register all state and outputs; reset takes priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            dout_q       <= FLOOR_W'(EMPTY_FLOOR);
            dout_valid_q <= 1'b0;
            wr_drop_q    <= 1'b0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            af_q         <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            wr_drop_q    <= wr_drop_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            af_q         <= af_d;
        end
    end

    // Payload storage, written on accepted pushes only.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; the valid bits alone decide what is queued.
        if (mem_we) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign count       = count_q;
    assign wr_drop     = wr_drop_q;

endmodule
